// File: rtl/mode_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mode_ctrl_pkg                                                  |
// | Purpose : Shared definitions for the front-panel mode controller: mode   |
// |           encodings for the clock-source mux select, adjust FSM state    |
// |           codes, and the mode stepping helper.                           |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package mode_ctrl_pkg;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SET   = 2'd1;
  localparam logic [1:0] MODE_ALARM = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    RPT      = 2'd2,
    WAIT_REL = 2'd3
  } adj_state_t;

  // RUN -> SET -> ALARM -> RUN; the unused code 3 falls back to RUN.
  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      MODE_RUN: nxt = MODE_SET;
      MODE_SET: nxt = MODE_ALARM;
      default:  nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mode_ctrl_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : btn_debounce                                                   |
// | Purpose : Synchronises a raw asynchronous push-button into the clk       |
// |           domain, debounces it, and emits a one-cycle strobe on each     |
// |           debounced press.                                               |
// | Ports   : clk   - system clock                                           |
// |           rst_n - asynchronous active-low reset                          |
// |           raw   - raw button, active-high, asynchronous                  |
// |           level - debounced button level                                 |
// |           press - 1-cycle strobe on debounced 0->1                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module btn_debounce #(
  parameter int DB_CYCLES = 20000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        // This is the DB_CYCLES-th consecutive disagreeing cycle.
        level <= sync_q2;
        press <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mode_ctrl                                                      |
// | Purpose : Front-panel controller ahead of the clock-source mux. Owns the |
// |           2-bit mode register and generates adjust pulses with           |
// |           auto-repeat while the adjust button is held in SET mode.       |
// | Ports   : clk      - system clock                                        |
// |           rst_n    - asynchronous active-low reset                       |
// |           btn_mode - raw mode button, active-high, asynchronous          |
// |           btn_adj  - raw adjust button, active-high, asynchronous        |
// |           mode     - mux select (0=RUN, 1=SET, 2=ALARM)                  |
// |           change   - registered 1-cycle adjust pulse                     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mode_ctrl
  import mode_ctrl_pkg::*;
#(
  parameter int DB_CYCLES     = 20000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic [1:0] mode,
  output logic       change
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             mode_level_unused;
  logic             mode_press;
  logic             adj_level;
  logic             adj_press;
  adj_state_t       adj_state;
  logic [CNT_W-1:0] adj_cnt;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_mode),
    .level (mode_level_unused),
    .press (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_adj (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_adj),
    .level (adj_level),
    .press (adj_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= MODE_RUN;
      change    <= 1'b0;
      adj_state <= IDLE;
      adj_cnt   <= '0;
    end else begin
      change <= 1'b0;
      if (mode_press) begin
        // A mode change wins: any same-cycle adjust strobe is dropped and
        // an in-progress or still-held adjust must be released first.
        mode    <= next_mode(mode);
        adj_cnt <= '0;
        if (adj_state == HOLD || adj_state == RPT || adj_level)
          adj_state <= WAIT_REL;
        else
          adj_state <= IDLE;
      end else begin
        case (adj_state)
          IDLE: begin
            if (adj_press) begin
              adj_cnt <= '0;
              if (mode == MODE_SET) begin
                change    <= 1'b1;
                adj_state <= HOLD;
              end else begin
                adj_state <= WAIT_REL;
              end
            end
          end
          HOLD: begin
            if (!adj_level) begin
              adj_state <= IDLE;
            end else if (adj_cnt >= DELAY_LAST) begin
              change    <= 1'b1;
              adj_cnt   <= '0;
              adj_state <= RPT;
            end else if (adj_cnt != '1) begin
              adj_cnt <= adj_cnt + CNT_W'(1);
            end
          end
          RPT: begin
            if (!adj_level) begin
              adj_state <= IDLE;
            end else if (adj_cnt >= PERIOD_LAST) begin
              change  <= 1'b1;
              adj_cnt <= '0;
            end else if (adj_cnt != '1) begin
              adj_cnt <= adj_cnt + CNT_W'(1);
            end
          end
          default: begin
            if (!adj_level) adj_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mode_ctrl                                                   |
// | Purpose : Self-checking bench for mode_ctrl with scoreboard queues of    |
// |           expected mode updates and change pulses.                       |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_mode_ctrl;
  import mode_ctrl_pkg::*;

  localparam int DB  = 4;
  localparam int RD  = 16;
  localparam int RP  = 4;
  localparam int LAT = DB + 3;  // raw edge -> mode/change update

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_adj = 1'b0;
  logic [1:0] mode;
  logic       change;

  mode_ctrl #(
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_adj(btn_adj),
    .mode(mode), .change(change)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] val;
  } mode_exp_t;

  mode_exp_t  mode_q[$];
  int         chg_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] prev_mode = 2'd0;

  // Scoreboard monitor: every observed mode update and change pulse must
  // match the next expectation in its queue.
  always @(negedge clk) begin
    mode_exp_t me;
    int        ce;
    if (rst_n) begin
      if (change === 1'b1) begin
        checks++;
        if (chg_q.size() == 0) begin
          errors++;
          $display("FAIL change_pulse: unexpected pulse at cycle %0d, none expected", cyc);
        end else begin
          ce = chg_q.pop_front();
          if (cyc !== ce) begin
            errors++;
            $display("FAIL change_pulse: pulse at cycle %0d, expected cycle %0d", cyc, ce);
          end
        end
        if (mode !== MODE_SET) begin
          errors++;
          $display("FAIL change_gating: pulse with mode=%0d, expected mode=1", mode);
        end
      end
      if (mode !== prev_mode) begin
        checks++;
        if (mode_q.size() == 0) begin
          errors++;
          $display("FAIL mode_update: mode %0d->%0d at cycle %0d, none expected", prev_mode, mode, cyc);
        end else begin
          me = mode_q.pop_front();
          if (cyc !== me.at || mode !== me.val) begin
            errors++;
            $display("FAIL mode_update: mode=%0d at cycle %0d, expected mode=%0d at cycle %0d",
                     mode, cyc, me.val, me.at);
          end
        end
      end
    end
    prev_mode = mode;
  end

  task automatic raise(input bit adj, output int t0);
    @(posedge clk); #1;
    t0 = cyc;
    if (adj) btn_adj = 1'b1; else btn_mode = 1'b1;
  endtask

  task automatic hold_release(input bit adj, input int n);
    repeat (n) @(posedge clk);
    #1;
    if (adj) btn_adj = 1'b0; else btn_mode = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    checks++;
    if (mode_q.size() != 0 || chg_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d mode and %0d change expectations left, expected 0 and 0",
               name, mode_q.size(), chg_q.size());
      mode_q.delete();
      chg_q.delete();
    end
  endtask

  task automatic press_mode(input logic [1:0] expect_mode);
    int t0;
    raise(1'b0, t0);
    mode_q.push_back('{t0 + LAT, expect_mode});
    hold_release(1'b0, 10);
    idle(10);
  endtask

  task automatic test_reset_init();
    #2;
    checks++;
    if (mode !== 2'd0 || change !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: mode=%0d change=%0b, expected mode=0 change=0", mode, change);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_mode_step();
    int t0;
    press_mode(2'd1);
    press_mode(2'd2);
    press_mode(2'd0);
    press_mode(2'd1);
    // Bounce pattern 1,0,1,0 one cycle each: never stable long enough.
    raise(1'b0, t0);
    @(posedge clk); #1; btn_mode = 1'b0;
    @(posedge clk); #1; btn_mode = 1'b1;
    @(posedge clk); #1; btn_mode = 1'b0;
    idle(15);
    @(negedge clk);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL bounce_reject: mode=%0d, expected mode=1", mode);
    end
    check_drained("mode_step");
  endtask

  task automatic test_single_adj();
    int t0;
    raise(1'b1, t0);
    chg_q.push_back(t0 + LAT);
    hold_release(1'b1, 10);
    idle(15);
    check_drained("single_adj");
  endtask

  task automatic test_auto_repeat();
    int t0;
    raise(1'b1, t0);
    chg_q.push_back(t0 + LAT);
    for (int k = 0; k < 6; k++) chg_q.push_back(t0 + LAT + RD + k * RP);
    hold_release(1'b1, 40);
    idle(20);
    check_drained("auto_repeat");
  endtask

  task automatic test_gating();
    int t0;
    int ta;
    press_mode(2'd2);
    press_mode(2'd0);
    raise(1'b1, ta);
    idle(30);
    raise(1'b0, t0);
    mode_q.push_back('{t0 + LAT, 2'd1});
    hold_release(1'b0, 10);
    idle(5);
    @(negedge clk);
    checks++;
    if (mode !== 2'd1 || change !== 1'b0) begin
      errors++;
      $display("FAIL gating_held: mode=%0d change=%0b, expected mode=1 change=0", mode, change);
    end
    hold_release(1'b1, 0);
    idle(15);
    raise(1'b1, t0);
    chg_q.push_back(t0 + LAT);
    hold_release(1'b1, 10);
    idle(15);
    check_drained("gating");
  endtask

  task automatic test_simultaneous();
    int t0;
    @(posedge clk); #1;
    t0 = cyc;
    btn_mode = 1'b1;
    btn_adj  = 1'b1;
    mode_q.push_back('{t0 + LAT, 2'd2});
    idle(10);
    @(negedge clk);
    checks++;
    if (dut.adj_state !== WAIT_REL) begin
      errors++;
      $display("FAIL simul_state: adj_state=%0d, expected %0d", dut.adj_state, WAIT_REL);
    end
    @(posedge clk); #1;
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
    idle(15);
    check_drained("simultaneous");
  endtask

  task automatic test_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'd0 || change !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: mode=%0d change=%0b, expected mode=0 change=0", mode, change);
    end
    idle(3);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (mode !== 2'd0 || change !== 1'b0) begin
        errors++;
        $display("FAIL reset_after: mode=%0d change=%0b, expected mode=0 change=0", mode, change);
      end
    end
    check_drained("reset");
  endtask

  initial begin
    test_reset_init();
    test_mode_step();
    test_single_adj();
    test_auto_repeat();
    test_gating();
    test_simultaneous();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
